// File: rtl/dma_grant_sequencer.sv
// Registers the DMA arbiter's winner into a held grant, runs the start/done
// handshake with the transfer engine and requests a yield once a beat quantum is used.
module dma_grant_sequencer #(
   parameter int CH_NUM  = 31,
   parameter int CH_BITS = $clog2(CH_NUM),
   parameter int QUANTUM = 16
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic [CH_NUM-1:0]  req,
   input  logic [CH_BITS-1:0] next_ch,
   input  logic               de_beat,
   input  logic               de_done,
   output logic [CH_BITS-1:0] cur_ch,
   output logic               advance,
   output logic               ch_start,
   output logic               ch_valid,
   output logic               ch_yield
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      RELEASE
   } state_t;

   localparam logic [7:0] QUANTUM_Q  = QUANTUM[7:0];
   localparam logic       YIELD_ON   = (QUANTUM != 0);
   localparam logic [7:0] BEAT_MAX   = 8'hFF;

   state_t     state;
   logic [7:0] beat_count;

   // Grant state machine; cur_ch only moves on IDLE->START and in RELEASE,
   // so it is stable for the whole time the engine owns the channel.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state      <= IDLE;
         cur_ch     <= '0;
         beat_count <= '0;
         ch_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  cur_ch <= next_ch;
                  state  <= START;
               end
            end
            START: begin
               if (req[cur_ch]) begin
                  beat_count <= '0;
                  ch_valid   <= 1'b1;
                  state      <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (de_beat && (beat_count != BEAT_MAX)) begin
                  beat_count <= beat_count + 8'd1;
               end
               if (de_done) begin
                  ch_valid <= 1'b0;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               cur_ch <= next_ch;
               state  <= (|req) ? START : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ch_valid is high exactly in BUSY, so gating with it confines yield to the grant.
   assign ch_yield = YIELD_ON && ch_valid && (beat_count >= QUANTUM_Q);
   assign ch_start = (state == START) && req[cur_ch];
   assign advance  = (state == RELEASE);

endmodule

// File: doc/dma_grant_sequencer.md
# dma_grant_sequencer

Sequencer that turns the DMA channel grant arbiter's combinational winner into a registered, held grant. It sits directly downstream of the arbiter. It feeds the current channel index back to the arbiter (rotation base) and drives the arbiter's `advance` input. It hands the granted channel to the DMA transfer engine with a start/done handshake and enforces a per-grant beat quantum, so one channel cannot starve the others.

## Interface
- `CH_NUM`, default 31: number of DMA channels (2..31).
- `CH_BITS`, default `$clog2(CH_NUM)`: channel index width.
- `QUANTUM`, default 16: beats allowed per grant before yield is requested; 0 disables yielding; max 255.

Ports:
- `HCLK`  in  1: clock; all state updates on rising edge.
- `HRESET`  in  1: reset, synchronous and active-high.
- `req`  in  CH_NUM: per-channel transfer requests (same vector the arbiter sees).
- `next_ch`  in  CH_BITS: arbiter winner, computed with rotation base `cur_ch` and this block's `advance`.
- `de_beat`  in  1: one-cycle pulse per completed bus beat of the granted channel.
- `de_done`  in  1: one-cycle pulse; engine finished or yielded the granted channel.
- `cur_ch`  out  CH_BITS: registered current/granted channel index.
- `advance`  out  1: to arbiter; forces rotation past `cur_ch`.
- `ch_start`  out  1: one-cycle start pulse to engine for `cur_ch`.
- `ch_valid`  out  1: grant held; engine owns `cur_ch`.
- `ch_yield`  out  1: quantum exhausted; engine must end at the next beat boundary.

## Operation
- States: IDLE, START, BUSY, RELEASE. Reset state is IDLE.
- IDLE: `advance`=0. If `|req`=1, then `cur_ch` <= `next_ch` and go to START. The arbiter keeps `cur_ch` if it still requests, otherwise it picks the next requester in rotation.
- START: `ch_start` = `req[cur_ch]` (combinational).
  - If `req[cur_ch]`=1: clear the beat counter and go to BUSY.
  - Else (request withdrawn): go to IDLE with no start.
- BUSY: `ch_valid`=1.
  - Each `de_beat` increments the 8-bit beat counter. The counter saturates at 255.
  - `ch_yield` = (QUANTUM != 0) && (count >= QUANTUM). It is registered-state based and holds until leaving BUSY.
  - On `de_done`, go to RELEASE.
  - `req[cur_ch]` deasserting in BUSY is ignored, because the engine owns termination.
- RELEASE: `advance`=1 for exactly this cycle.
  - `cur_ch` <= `next_ch`. The arbiter skips the current channel. If the current channel is the sole requester, it wraps back to itself.
  - If `|req`=1, go to START; else go to IDLE.
  - When the next state is IDLE, `cur_ch` is still loaded with `next_ch`. When `req`=0, that value equals `cur_ch`.
- `cur_ch` changes only on IDLE->START and in RELEASE. It never changes while `ch_valid`=1.
- Simultaneous `de_beat` and `de_done`: the beat is counted, and the transition to RELEASE still occurs.
- `de_done` or `de_beat` outside BUSY is ignored.
- `next_ch` is trusted; no range check is done. Values >= CH_NUM cannot come from the arbiter.

## Timing
- Reset values: `cur_ch`=0, `ch_valid`=0, `ch_start`=0, `ch_yield`=0, `advance`=0, beat counter=0, state IDLE.
- `HRESET` mid-transfer: in the next cycle every output is at its reset value. No `advance` is issued and no pending release is completed.
- `req` rises in cycle 0 (IDLE):
  - START in cycle 1, with `cur_ch` valid and `ch_start` high.
  - BUSY from cycle 2, with `ch_valid` high.
- `de_done` in cycle n (BUSY):
  - RELEASE in cycle n+1, with `advance`=1 and `ch_valid`=0.
  - START for the next grant in cycle n+2.
  - The minimum grant-to-grant gap is 2 idle cycles for `ch_valid`.
- Yield: the QUANTUM-th `de_beat` in cycle k gives `ch_yield`=1 from cycle k+1.
- Outputs:
  - `cur_ch`, `ch_valid` and `ch_yield` derive only from registers.
  - `ch_start` and `advance` are decoded from the state register, plus `req` for `ch_start`.

## Test plan
- Reset then single request: `req`=1<<5 held, `next_ch`=5 → `cur_ch`=5 and `ch_start` pulse in cycle 1, `ch_valid` from cycle 2. `de_done` → one `advance` cycle, `cur_ch` stays 5, then the next START.
- Round robin: `req`=channels 2, 7, 30 held, arbiter model in loop, `de_done` 3 cycles after each start → grant order 2, 7, 30, 2, exactly one `advance` per release.
- Quantum: QUANTUM=4, 6 `de_beat` pulses → `ch_yield` rises the cycle after the 4th beat and holds through the 6th. `de_done` → `ch_yield`=0 in RELEASE.
- Withdrawn request: `req[3]` drops while in START → no `ch_start`, return to IDLE, `ch_valid` never asserted.
- Reset mid-BUSY: `HRESET` 1 cycle during BUSY with count 9 → next cycle all outputs 0 and `cur_ch`=0. A later `de_done` pulse is ignored.
- Simultaneous `de_beat`+`de_done` at count QUANTUM-1 → RELEASE next cycle, `ch_yield` never asserted.
